// File: rtl/ddr5_rd_pkg.sv
// Shared types and burst-length constants for the DDR5 read data path.
package ddr5_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } rd_state_e;

  localparam int BL16_BEATS = 16;
  localparam int BC8_BEATS  = 8;

  function automatic int beats_for(input logic bc8);
    return bc8 ? BC8_BEATS : BL16_BEATS;
  endfunction

endpackage

// File: rtl/rd_out_buffer.sv
// Single output word register with valid/ready; a load may land on the pop edge.
module rd_out_buffer #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_bc8,
  input  logic         ready,
  output logic         free,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         bc8
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         bc8_q, bc8_d;

  // Register can take a new word when empty or being drained this edge.
  assign free = !valid_q || ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    bc8_d   = bc8_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = '0;
      bc8_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      bc8_d   = load_bc8;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      bc8_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      bc8_q   <= bc8_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign bc8   = bc8_q;

endmodule

// File: rtl/rd_burst_gatherer.sv
// Gathers one BL16/BC8 burst of DQ beats into a wide word and hands it upstream
// through a gather register plus a one-word output register.
module rd_burst_gatherer
  import ddr5_rd_pkg::*;
#(
  parameter int DQ_W   = 8,
  parameter int BL_MAX = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   start,
  input  logic                   bc8,
  input  logic [DQ_W-1:0]        dq_in,
  input  logic                   rd_ready,
  output logic [DQ_W*BL_MAX-1:0] rd_data,
  output logic                   rd_bc8,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   overflow
);

  localparam int W  = DQ_W * BL_MAX;
  localparam int CW = $clog2(BL_MAX);

  rd_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bc8_q, bc8_d;
  logic [W-1:0]   gather_q, gather_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;

  logic           load;
  logic [W-1:0]   load_data;
  logic [W-1:0]   word_full;
  logic [CW-1:0]  last_idx;
  logic           last;
  logic           out_free;

  assign last_idx = CW'(beats_for(bc8_q) - 1);
  assign last     = (cnt_q == last_idx);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bc8_d     = bc8_q;
    gather_d  = gather_q;
    ovf_d     = 1'b0;
    load      = 1'b0;
    load_data = gather_q;
    // Current gather contents with this cycle's beat merged in.
    word_full = gather_q;
    word_full[cnt_q*DQ_W +: DQ_W] = dq_in;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          cnt_d    = '0;
          bc8_d    = bc8;
          gather_d = '0;
        end
      end
      CAPTURE: begin
        if (!last) begin
          gather_d = word_full;
          cnt_d    = cnt_q + 1'b1;
          ovf_d    = start;
        end else if (out_free) begin
          load      = 1'b1;
          load_data = word_full;
          cnt_d     = '0;
          gather_d  = '0;
          state_d   = start ? CAPTURE : IDLE;
          if (start) bc8_d = bc8;
        end else begin
          // Output register full: park the word; a start here cannot be honoured.
          gather_d = word_full;
          state_d  = HOLD;
          ovf_d    = start;
        end
      end
      HOLD: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = gather_q;
          cnt_d     = '0;
          gather_d  = '0;
          state_d   = start ? CAPTURE : IDLE;
          if (start) bc8_d = bc8;
        end else begin
          ovf_d = start;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bc8_d    = 1'b0;
      gather_d = '0;
      ovf_d    = 1'b0;
      load     = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bc8_q    <= 1'b0;
      gather_q <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bc8_q    <= bc8_d;
      gather_q <= gather_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  rd_out_buffer #(.W(W)) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .load      (load),
    .load_data (load_data),
    .load_bc8  (bc8_q),
    .ready     (rd_ready),
    .free      (out_free),
    .valid     (rd_valid),
    .data      (rd_data),
    .bc8       (rd_bc8)
  );

  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rd_burst_gatherer.sv
// Directed bench for rd_burst_gatherer: capture, BC8 fill, back-to-back, backpressure, overflow, flush/reset.
module tb_rd_burst_gatherer;

  localparam int DQ_W   = 8;
  localparam int BL_MAX = 16;
  localparam int W      = DQ_W * BL_MAX;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            start = 1'b0;
  logic            bc8 = 1'b0;
  logic [DQ_W-1:0] dq_in = '0;
  logic            rd_ready = 1'b0;
  logic [W-1:0]    rd_data;
  logic            rd_bc8;
  logic            rd_valid;
  logic            busy;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  rd_burst_gatherer #(.DQ_W(DQ_W), .BL_MAX(BL_MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .start    (start),
    .bc8      (bc8),
    .dq_in    (dq_in),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_bc8   (rd_bc8),
    .rd_valid (rd_valid),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (edge k); returns 1ns after edge k.
  task automatic start_burst(input logic b8);
    start = 1'b1;
    bc8   = b8;
    tick();
    start = 1'b0;
    bc8   = 1'b0;
  endtask

  task automatic feed(input logic [7:0] base, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      dq_in = base + 8'(first + i);
      tick();
    end
  endtask

  function automatic logic [W-1:0] build(input logic [7:0] base, input int n);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i*DQ_W +: DQ_W] = base + 8'(i);
    return w;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
    total++; if (overflow !== 1'b0 || rd_bc8 !== 1'b0) begin bad++; $display("FAIL reset_ovf_bc8 got=%0b%0b exp=00", overflow, rd_bc8); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bl16();
    rd_ready = 1'b1;
    start_burst(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bl16_busy got=%0b exp=1", busy); end
    feed(8'h10, 0, 15);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bl16_early_valid got=%0b exp=0", rd_valid); end
    feed(8'h10, 15, 1);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL bl16_valid got=%0b exp=1", rd_valid); end
    total++; if (rd_data[7:0] !== 8'h10 || rd_data[127:120] !== 8'h1F) begin bad++; $display("FAIL bl16_ends got=%0h/%0h exp=10/1f", rd_data[7:0], rd_data[127:120]); end
    total++; if (rd_data !== build(8'h10, 16)) begin bad++; $display("FAIL bl16_data got=%0h exp=%0h", rd_data, build(8'h10, 16)); end
    total++; if (rd_bc8 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bl16_bc8_busy got=%0b%0b exp=00", rd_bc8, busy); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bl16_pop got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_bc8();
    rd_ready = 1'b1;
    start_burst(1'b1);
    feed(8'hA0, 0, 7);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bc8_early_valid got=%0b exp=0", rd_valid); end
    feed(8'hA0, 7, 1);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL bc8_valid got=%0b exp=1", rd_valid); end
    total++; if (rd_data[63:0] !== 64'hA7A6A5A4A3A2A1A0) begin bad++; $display("FAIL bc8_low got=%0h exp=a7a6a5a4a3a2a1a0", rd_data[63:0]); end
    total++; if (rd_data[127:64] !== 64'h0) begin bad++; $display("FAIL bc8_high got=%0h exp=0", rd_data[127:64]); end
    total++; if (rd_bc8 !== 1'b1) begin bad++; $display("FAIL bc8_tag got=%0b exp=1", rd_bc8); end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_ready = 1'b1;
    start_burst(1'b0);
    feed(8'h20, 0, 15);
    dq_in = 8'h2F;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== build(8'h20, 16)) begin bad++; $display("FAIL b2b_word1 got=%0b/%0h exp=1/%0h", rd_valid, rd_data, build(8'h20, 16)); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_turn got=%0b exp=1", busy); end
    for (int i = 0; i < 16; i++) begin
      dq_in = 8'h40 + 8'(i);
      tick();
      total++;
      if (rd_valid !== (i == 15) || busy !== (i != 15)) begin
        bad++; $display("FAIL b2b_cycle%0d got=v%0b b%0b exp=v%0b b%0b", i, rd_valid, busy, i == 15, i != 15);
      end
    end
    total++; if (rd_data !== build(8'h40, 16)) begin bad++; $display("FAIL b2b_word2 got=%0h exp=%0h", rd_data, build(8'h40, 16)); end
    tick();
  endtask

  task automatic test_backpressure();
    rd_ready = 1'b0;
    start_burst(1'b0);
    feed(8'h50, 0, 16);
    total++; if (rd_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_word1 got=v%0b b%0b exp=v1 b0", rd_valid, busy); end
    start_burst(1'b0);
    feed(8'h60, 0, 16);
    total++; if (busy !== 1'b1 || rd_data !== build(8'h50, 16)) begin bad++; $display("FAIL bp_hold got=b%0b %0h exp=b1 %0h", busy, rd_data, build(8'h50, 16)); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%0b exp=1", overflow); end
    total++; if (rd_data !== build(8'h50, 16) || busy !== 1'b1) begin bad++; $display("FAIL bp_stable got=b%0b %0h exp=b1 %0h", busy, rd_data, build(8'h50, 16)); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_pulse got=%0b exp=0", overflow); end
    rd_ready = 1'b1;
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== build(8'h60, 16)) begin bad++; $display("FAIL bp_word2 got=%0b/%0h exp=1/%0h", rd_valid, rd_data, build(8'h60, 16)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b exp=0", busy); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_overflow_capture();
    rd_ready = 1'b1;
    start_burst(1'b0);
    feed(8'h70, 0, 5);
    dq_in = 8'h75;
    start = 1'b1;
    bc8   = 1'b1;
    tick();
    start = 1'b0;
    bc8   = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL cap_ovf got=%0b exp=1", overflow); end
    feed(8'h70, 6, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL cap_ovf_pulse got=%0b exp=0", overflow); end
    feed(8'h70, 7, 8);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL cap_early got=%0b exp=0", rd_valid); end
    feed(8'h70, 15, 1);
    total++; if (rd_valid !== 1'b1 || rd_data !== build(8'h70, 16) || rd_bc8 !== 1'b0) begin
      bad++; $display("FAIL cap_word got=%0b/%0b/%0h exp=1/0/%0h", rd_valid, rd_bc8, rd_data, build(8'h70, 16));
    end
    tick();
  endtask

  task automatic test_flush_reset();
    int vseen;
    rd_ready = 1'b1;
    start_burst(1'b0);
    feed(8'h80, 0, 9);
    flush = 1'b1;
    dq_in = 8'h89;
    tick();
    flush = 1'b0;
    total++; if (rd_data !== '0 || rd_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || rd_bc8 !== 1'b0) begin
      bad++; $display("FAIL flush_clear got=v%0b b%0b o%0b t%0b %0h exp=all0", rd_valid, busy, overflow, rd_bc8, rd_data);
    end
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      dq_in = 8'(i * 7);
      tick();
      if (rd_valid) vseen++;
    end
    total++; if (vseen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d exp=0", vseen); end
    rd_ready = 1'b0;
    start_burst(1'b1);
    feed(8'h30, 0, 8);
    total++; if (rd_valid !== 1'b1 || rd_bc8 !== 1'b1) begin bad++; $display("FAIL rst_preload got=%0b%0b exp=11", rd_valid, rd_bc8); end
    start_burst(1'b0);
    feed(8'h38, 0, 4);
    reset_n = 1'b0;
    tick();
    total++; if (rd_data !== '0 || rd_valid !== 1'b0 || busy !== 1'b0 || rd_bc8 !== 1'b0) begin
      bad++; $display("FAIL rst_clear got=v%0b b%0b t%0b %0h exp=all0", rd_valid, busy, rd_bc8, rd_data);
    end
    reset_n  = 1'b1;
    rd_ready = 1'b1;
    tick();
    start_burst(1'b1);
    feed(8'h90, 0, 8);
    total++; if (rd_valid !== 1'b1 || rd_bc8 !== 1'b1 || rd_data !== build(8'h90, 8)) begin
      bad++; $display("FAIL fresh_word got=%0b/%0b/%0h exp=1/1/%0h", rd_valid, rd_bc8, rd_data, build(8'h90, 8));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bl16();
    test_bc8();
    test_back_to_back();
    test_backpressure();
    test_overflow_capture();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
